// File: rtl/shift_sequencer.sv
// Shift sequencer: walks one 4-bit word through shift amounts 0..3 on an
// external barrel shifter. Each step holds the shifter inputs for DWELL
// settle cycles and then captures the shifter output.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for start; shifter inputs hold their last values
//   DRIVE   | shifter inputs stable, counting DWELL settle cycles
//   CAPTURE | result captured on entry; res_valid high this cycle
//   DONE    | sequence complete; done high for this one cycle
module shift_sequencer #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] data_in,
    output logic [3:0] sh_data,
    output logic [1:0] sh_amt,
    input  logic [3:0] sh_result,
    output logic       busy,
    output logic       res_valid,
    output logic [3:0] res_data,
    output logic [1:0] res_amt,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] dwell_cnt;
    logic       dwell_end;

    assign dwell_end = (dwell_cnt == DWELL_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides everything outside IDLE, and in
    // IDLE it suppresses a simultaneous start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (dwell_end) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (sh_amt == 2'd3) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = DRIVE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shifter drive, dwell counter and result capture. sh_amt only advances
    // on a CAPTURE->DRIVE step, so it stays at 3 after the last step and
    // holds its value when a sequence is aborted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data   <= 4'd0;
            sh_amt    <= 2'd0;
            dwell_cnt <= 8'd0;
            res_data  <= 4'd0;
            res_amt   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == DRIVE) begin
                        sh_data   <= data_in;
                        sh_amt    <= 2'd0;
                        dwell_cnt <= 8'd0;
                    end
                end
                DRIVE: begin
                    if (state_nxt == CAPTURE) begin
                        res_data <= sh_result;
                        res_amt  <= sh_amt;
                    end else if (state_nxt == DRIVE) begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                CAPTURE: begin
                    if (state_nxt == DRIVE) begin
                        sh_amt    <= sh_amt + 2'd1;
                        dwell_cnt <= 8'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign res_valid = (state == CAPTURE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: two instances (DWELL=4 and DWELL=1), each with
// a rotate-left shifter model, a timeline-based reference model and a
// negedge monitor that pops expected results from queues.
module tb_shift_sequencer;

    typedef struct packed {
        int       cyc;
        logic [1:0] amt;
        logic [3:0] data;
    } res_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] rotl4(input logic [3:0] w, input logic [1:0] n);
        logic [7:0] t;
        t = {w, w} << n;
        return t[7:4];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_lane
        localparam int D = (k == 0) ? 4 : 1;

        logic       rst = 1'b1;
        logic       start = 1'b0;
        logic       abort = 1'b0;
        logic [3:0] data_in = 4'd0;
        logic [3:0] sh_data;
        logic [1:0] sh_amt;
        logic [3:0] sh_result;
        logic       busy;
        logic       res_valid;
        logic [3:0] res_data;
        logic [1:0] res_amt;
        logic       done;
        bit         fin = 1'b0;

        // reference model: one sequence occupies cycles acc..end_cyc
        res_t       res_q[$];
        int         done_q[$];
        bit         have = 1'b0;
        int         acc = 0;
        int         end_cyc = 0;
        logic [3:0] word = 4'd0;
        res_t       last_res = '0;

        assign sh_result = rotl4(sh_data, sh_amt);

        shift_sequencer #(.DWELL(D)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .abort     (abort),
            .data_in   (data_in),
            .sh_data   (sh_data),
            .sh_amt    (sh_amt),
            .sh_result (sh_result),
            .busy      (busy),
            .res_valid (res_valid),
            .res_data  (res_data),
            .res_amt   (res_amt),
            .done      (done)
        );

        // model reaction to inputs sampled at edge e
        task automatic model_edge(input logic s, input logic a, input logic [3:0] d, input int e);
            bit busy_prev;
            busy_prev = have && (e - 1 >= acc) && (e - 1 <= end_cyc);
            if (!busy_prev) begin
                if (s && !a) begin
                    have    = 1'b1;
                    acc     = e;
                    end_cyc = e + 4 * (D + 1);
                    word    = d;
                    for (int i = 0; i < 4; i++) begin
                        res_q.push_back('{cyc: e + i * (D + 1) + D, amt: 2'(i), data: rotl4(d, 2'(i))});
                    end
                    done_q.push_back(end_cyc);
                end
            end else if (a) begin
                end_cyc = e - 1;
                while (res_q.size() > 0 && res_q[res_q.size() - 1].cyc >= e) void'(res_q.pop_back());
                while (done_q.size() > 0 && done_q[done_q.size() - 1] >= e) void'(done_q.pop_back());
            end
        endtask

        task automatic issue(input logic s, input logic a, input logic [3:0] d);
            @(negedge clk);
            #1;
            start   = s;
            abort   = a;
            data_in = d;
            model_edge(s, a, d, cyc + 1);
        endtask

        task automatic idle(input int n);
            repeat (n) issue(1'b0, 1'b0, 4'($urandom));
        endtask

        task automatic do_reset(input int hold);
            @(negedge clk);
            #3;
            rst = 1'b1;
            #1;
            chk($sformatf("L%0d rst busy", k), 32'(busy), 0);
            chk($sformatf("L%0d rst res_valid", k), 32'(res_valid), 0);
            chk($sformatf("L%0d rst done", k), 32'(done), 0);
            chk($sformatf("L%0d rst sh_data", k), 32'(sh_data), 0);
            chk($sformatf("L%0d rst sh_amt", k), 32'(sh_amt), 0);
            chk($sformatf("L%0d rst res_data", k), 32'(res_data), 0);
            chk($sformatf("L%0d rst res_amt", k), 32'(res_amt), 0);
            have = 1'b0;
            word = 4'd0;
            res_q.delete();
            done_q.delete();
            last_res = '0;
            repeat (hold) @(negedge clk);
            #3;
            rst = 1'b0;
        endtask

        // monitor: compare every cycle against the model timeline and queues
        always @(negedge clk) begin : mon
            int   c;
            int   m;
            bit   eb;
            res_t r;
            c  = cyc;
            eb = have && (c >= acc) && (c <= end_cyc);
            m  = 0;
            if (have) begin
                m = (((c < end_cyc) ? c : end_cyc) - acc) / (D + 1);
                if (m > 3) m = 3;
            end
            chk($sformatf("L%0d busy", k), 32'(busy), 32'(eb));
            chk($sformatf("L%0d sh_data", k), 32'(sh_data), 32'(have ? word : 4'd0));
            chk($sformatf("L%0d sh_amt", k), 32'(sh_amt), 32'(m));
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    chk($sformatf("L%0d unexpected res_valid", k), 32'(res_valid), 0);
                end else begin
                    r = res_q.pop_front();
                    chk($sformatf("L%0d res cycle", k), 32'(c), 32'(r.cyc));
                    chk($sformatf("L%0d res_amt strobe", k), 32'(res_amt), 32'(r.amt));
                    chk($sformatf("L%0d res_data strobe", k), 32'(res_data), 32'(r.data));
                    last_res = r;
                end
            end else if (res_q.size() > 0 && res_q[0].cyc <= c) begin
                r = res_q.pop_front();
                chk($sformatf("L%0d missing res_valid", k), 32'(res_valid), 1);
                last_res = r;
            end
            chk($sformatf("L%0d res_data hold", k), 32'(res_data), 32'(last_res.data));
            chk($sformatf("L%0d res_amt hold", k), 32'(res_amt), 32'(last_res.amt));
            if (done) begin
                if (done_q.size() == 0) begin
                    chk($sformatf("L%0d unexpected done", k), 32'(done), 0);
                end else begin
                    chk($sformatf("L%0d done cycle", k), 32'(c), 32'(done_q.pop_front()));
                end
            end else if (done_q.size() > 0 && done_q[0] <= c) begin
                void'(done_q.pop_front());
                chk($sformatf("L%0d missing done", k), 32'(done), 1);
            end
        end

        initial begin
            do_reset(2);
            idle(2);
            // directed word: 1000 on DWELL=4, 0110 on DWELL=1
            issue(1'b1, 1'b0, (k == 0) ? 4'b1000 : 4'b0110);
            idle(4 * (D + 1) + 4);
            // start together with abort in IDLE is ignored
            issue(1'b1, 1'b1, 4'b0111);
            idle(3);
            // second start while busy is ignored
            issue(1'b1, 1'b0, 4'b1100);
            idle(3);
            issue(1'b1, 1'b0, 4'b0101);
            idle(4 * (D + 1) + 4);
            // abort in the DRIVE cycle following the second capture
            issue(1'b1, 1'b0, 4'b1011);
            idle(2 * D + 2);
            issue(1'b0, 1'b1, 4'b0000);
            idle(6);
            // start held high: back-to-back sequences
            repeat (12 * (D + 1) + 6) issue(1'b1, 1'b0, 4'b1001);
            idle(4 * (D + 1) + 4);
            // asynchronous reset in the middle of DRIVE
            issue(1'b1, 1'b0, 4'b1110);
            idle(2);
            do_reset(2);
            issue(1'b1, 1'b0, 4'b0011);
            idle(4 * (D + 1) + 4);
            // random traffic
            repeat (400) issue($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, 4'($urandom));
            idle(4 * (D + 1) + 4);
            chk($sformatf("L%0d leftover results", k), 32'(res_q.size()), 0);
            chk($sformatf("L%0d leftover done", k), 32'(done_q.size()), 0);
            fin = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (g_lane[0].fin && g_lane[1].fin) break;
        end
        n_checks++;
        if (!(g_lane[0].fin && g_lane[1].fin)) begin
            n_fail++;
            $display("FAIL timeout: lanes finished=%0d/%0d required=1/1", g_lane[0].fin, g_lane[1].fin);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one parameter: DWELL, default 4, settle cycles per shift step (legal 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to sequence one word.
REQ-005 The block SHALL have port abort, input, 1, synchronous cancel of a running sequence.
REQ-006 The block SHALL have port data_in, input, 4, word to be shifted, sampled on start acceptance.
REQ-007 The block SHALL have port sh_data, output, 4, word driven to the downstream 4-bit barrel shifter data input.
REQ-008 The block SHALL have port sh_amt, output, 2, shift amount driven to the barrel shifter.
REQ-009 The block SHALL have port sh_result, input, 4, combinational barrel-shifter output.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port res_valid, output, 1, one-cycle strobe qualifying res_data/res_amt.
REQ-012 The block SHALL have port res_data, output, 4, captured shifter result.
REQ-013 The block SHALL have port res_amt, output, 2, shift amount belonging to res_data.
REQ-014 The block SHALL have port done, output, 1, one-cycle strobe at sequence completion.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, CAPTURE, DONE; all outputs SHALL be registered or decoded from state only.
REQ-016 In IDLE with start=1 and abort=0, the block SHALL latch data_in into sh_data, set sh_amt=0, clear the dwell counter, and enter DRIVE.
REQ-017 In DRIVE the block SHALL hold sh_data/sh_amt stable for exactly DWELL cycles, then enter CAPTURE.
REQ-018 On the edge entering CAPTURE, res_data SHALL load sh_result and res_amt SHALL load sh_amt; res_valid SHALL be 1 for exactly the CAPTURE cycle.
REQ-019 From CAPTURE, if sh_amt<3 the block SHALL increment sh_amt and re-enter DRIVE; if sh_amt=3 it SHALL enter DONE (sh_amt SHALL NOT wrap to 0 in that case).
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE; sh_data and sh_amt SHALL retain their last values in IDLE.
REQ-021 Start-to-done latency SHALL be 4*(DWELL+1) cycles from the accepting edge to the edge asserting done; exactly four res_valid strobes with res_amt 0,1,2,3 in order SHALL occur per sequence.
REQ-022 start SHALL be ignored in DRIVE, CAPTURE and DONE; a start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no further res_valid and no done; res_data/res_amt SHALL keep their last captured values.
REQ-024 abort and start both high in IDLE SHALL leave the block in IDLE (abort wins).
REQ-025 The dwell counter SHALL be 8 bits and SHALL be cleared on every entry to DRIVE.

Reset
REQ-026 rst=1 SHALL immediately, without a clock, force IDLE, busy=0, res_valid=0, done=0, sh_data=0, sh_amt=0, res_data=0, res_amt=0, counter=0.
REQ-027 rst asserted mid-sequence SHALL discard the sequence; the first start after rst deassertion SHALL begin a fresh sequence at sh_amt=0.

Verification (bench models the shifter as rotate-left by sh_amt)
REQ-028 DWELL=4, data_in=1000, start one cycle -> res_valid strobes with (res_amt,res_data) = (0,1000),(1,0001),(2,0010),(3,0100); done exactly 20 cycles after acceptance; busy high throughout.
REQ-029 DWELL=1, data_in=0110 -> results 0110,1100,1001,0011; done 8 cycles after acceptance; sh_data stable at 0110 throughout.
REQ-030 start pulsed again with data_in=0101 while busy on word 1100 -> ignored; results match 1100 only (1100,1001,0011,0110).
REQ-031 abort asserted in the DRIVE cycle after the second res_valid -> IDLE next edge, busy=0, no done, res_data holds the amt=1 result.
REQ-032 rst asserted asynchronously mid-DRIVE (between edges) -> all outputs 0 before next edge; new start with 0011 yields 0011,0110,1100,1001.
REQ-033 start held high continuously with data_in=1001 -> back-to-back sequences, one IDLE cycle between done and the next sequence's DRIVE entry.
